mem_responder: RTL and testbench
================================

# mem_responder

Synthesizable memory responder on the far side of the core's instruction- and data-memory ports. It clears data memory and loads a program over a valid/ready stream, then releases the core from reset. It then serves instruction fetches and data reads with a fixed 1-cycle read latency and accepts data writes. It is the counterpart of the core's fetch/load/store initiator and of the bench monitor that observes those same ports.

## Interface
Parameters:
- INST_ADDR_W, 12, instruction word-address width
- INST_DATA_W, 32, instruction width
- DMEM_ADDR_W, 12, data word-address width
- DMEM_DATA_W, 32, data width
- IMEM_DEPTH, 1024, implemented instruction words (≤ 2**INST_ADDR_W)
- DMEM_DEPTH, 1024, implemented data words (≤ 2**DMEM_ADDR_W)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- load_valid  in  1  program beat valid
- load_ready  out  1  responder accepts beat (LOAD state only)
- load_data  in  INST_DATA_W  instruction word
- load_last  in  1  final beat of program
- core_rst_n  out  1  core reset; low until RUN
- imem_en  in  1  fetch request
- imem_addr  in  INST_ADDR_W  fetch word address
- imem_instr  out  INST_DATA_W  fetched instruction, registered
- dmem_wen  in  1  data write
- dmem_waddr  in  DMEM_ADDR_W  write word address
- dmem_wdata  in  DMEM_DATA_W  write data
- dmem_ren  in  1  data read request
- dmem_raddr  in  DMEM_ADDR_W  read word address
- dmem_rdata  out  DMEM_DATA_W  read data, registered
- err_oob  out  1  sticky: out-of-range access or load overflow

## Operation
- State machine: CLEAR → LOAD → RUN. Reset (rst low) forces CLEAR with ptr=0.
- CLEAR: writes 0 to dmem[ptr], ptr++ each cycle. After writing DMEM_DEPTH-1: ptr←0, go to LOAD. Core ports are ignored.
- LOAD: load_ready=1. A beat is accepted on load_valid&&load_ready: imem[ptr]←load_data, ptr++.
  - Accepted beat with load_last → RUN.
  - Accepted beat at ptr==IMEM_DEPTH-1 without load_last → RUN and set err_oob. Further beats are never accepted (load_ready=0).
- RUN: load_ready=0.
  - Fetch: imem_en high → imem_instr←imem[imem_addr] next edge.
  - Read: dmem_ren high → dmem_rdata←dmem[dmem_raddr] next edge.
  - Write: dmem_wen high → dmem[dmem_waddr]←dmem_wdata.
- Out-of-range (addr ≥ depth) in RUN: reads return 0, writes are dropped, err_oob sets. err_oob clears only on reset.
- Simultaneous read and write to the same dmem address: read-first. rdata returns the old value; the new value is visible on the next read.
- Requests in CLEAR/LOAD have no effect on memory. imem_instr and dmem_rdata hold their last value.
- Instruction memory contents are not cleared by reset. A reset mid-LOAD restarts CLEAR and the program must be reloaded from word 0.

## Timing
- Reset values: load_ready=0, core_rst_n=0, imem_instr=0, dmem_rdata=0, err_oob=0, state=CLEAR, ptr=0.
- rst assertion drops core_rst_n and load_ready immediately (async). Release takes effect at the first posedge with rst high.
- CLEAR lasts exactly DMEM_DEPTH cycles. load_ready rises the cycle after the last clear write.
- core_rst_n is registered: it rises on the edge that enters RUN, i.e. the cycle after the final accepted beat.
- Read latency is exactly 1 cycle for both imem and dmem. Output holds when the enable is low, so the data is stable when sampled the cycle after the request.
- Write takes effect at the request edge. A read issued on the following cycle returns the new data.
- Back-to-back requests are accepted every cycle. There is no stall or backpressure on core ports.

## Structure
- Package mem_resp_pkg: state enum (CLEAR, LOAD, RUN) and default depth/width constants.
- One sub-module sync_ram_1r1w (parameterized depth/width; 1 write port, 1 registered read port with enable, read-first). It is instanced for imem (write port muxed to loader) and dmem (write port muxed between clearer and core).
- Top holds the FSM, ptr counter, range checks, err_oob and core_rst_n flops.

## Test plan
- Reset with DMEM_DEPTH=16 → load_ready rises after exactly 16 cycles; dmem reads in RUN all return 0x00000000.
- Load 3 beats 0x11111111, 0x22222222, 0x33333333 (last on 3rd) with load_valid gaps → core_rst_n rises the cycle after beat 3; fetches at addr 0,1,2 return the three words 1 cycle after imem_en.
- Write 0xDEADBEEF to dmem addr 5, read addr 5 on the next cycle → 0xDEADBEEF one cycle later. A same-cycle read/write of addr 5 with 0xCAFEF00D returns 0xDEADBEEF.
- Read from dmem addr 2000 with DMEM_DEPTH=1024 → rdata 0, err_oob=1 and stays 1. A write to addr 2000 does not alter any in-range word.
- Stream IMEM_DEPTH+2 beats without load_last → exactly IMEM_DEPTH beats accepted, err_oob=1, RUN entered.
- Assert rst mid-LOAD after 2 beats → core_rst_n/load_ready low immediately; after release, CLEAR repeats and loading restarts at word 0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the memory responder: phase enum, default
// geometry, and an address-width helper.
package mem_resp_pkg;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_e;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;

  // Index width for a memory of n words; a 1-word memory still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_ram_1r1w.sv
// One write port and one registered, enabled read port. The read is read-first.
// rzero forces a read of zero for callers that detect out-of-range addresses.
module sync_ram_1r1w #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rzero,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The array is never reset; only the output register is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= rzero ? '0 : mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// Memory responder. It clears dmem, loads the program into imem over a
// valid/ready stream, then serves core fetches, reads and writes.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int INST_ADDR_W = DEF_ADDR_W,
  parameter int INST_DATA_W = DEF_DATA_W,
  parameter int DMEM_ADDR_W = DEF_ADDR_W,
  parameter int DMEM_DATA_W = DEF_DATA_W,
  parameter int IMEM_DEPTH  = DEF_DEPTH,
  parameter int DMEM_DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INST_DATA_W-1:0] load_data,
  input  logic                   load_last,
  output logic                   core_rst_n,
  input  logic                   imem_en,
  input  logic [INST_ADDR_W-1:0] imem_addr,
  output logic [INST_DATA_W-1:0] imem_instr,
  input  logic                   dmem_wen,
  input  logic [DMEM_ADDR_W-1:0] dmem_waddr,
  input  logic [DMEM_DATA_W-1:0] dmem_wdata,
  input  logic                   dmem_ren,
  input  logic [DMEM_ADDR_W-1:0] dmem_raddr,
  output logic [DMEM_DATA_W-1:0] dmem_rdata,
  output logic                   err_oob
);
  localparam int IA    = clog2_min1(IMEM_DEPTH);
  localparam int DA    = clog2_min1(DMEM_DEPTH);
  localparam int PTR_W = (IA > DA) ? IA : DA;

  localparam logic [PTR_W-1:0]     I_LAST = PTR_W'(IMEM_DEPTH - 1);
  localparam logic [PTR_W-1:0]     D_LAST = PTR_W'(DMEM_DEPTH - 1);
  localparam logic [INST_ADDR_W:0] I_LIM  = (INST_ADDR_W + 1)'(IMEM_DEPTH);
  localparam logic [DMEM_ADDR_W:0] D_LIM  = (DMEM_ADDR_W + 1)'(DMEM_DEPTH);

  state_e state, state_nx;
  logic [PTR_W-1:0] ptr;

  logic beat, i_oob, rd_oob, wr_oob;
  logic i_we, i_re, d_we, d_re;
  logic [DA-1:0]          d_waddr;
  logic [DMEM_DATA_W-1:0] d_wdata;

  assign beat   = load_valid && load_ready;
  assign i_oob  = {1'b0, imem_addr}  >= I_LIM;
  assign rd_oob = {1'b0, dmem_raddr} >= D_LIM;
  assign wr_oob = {1'b0, dmem_waddr} >= D_LIM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (ptr == D_LAST) state_nx = LOAD;
      LOAD:    if (beat && (load_last || ptr == I_LAST)) state_nx = RUN;
      default: ;
    endcase
  end

  // Memory port steering. The core ports are live only in RUN.
  always_comb begin
    load_ready = 1'b0;
    i_we       = 1'b0;
    i_re       = 1'b0;
    d_we       = 1'b0;
    d_re       = 1'b0;
    d_waddr    = dmem_waddr[DA-1:0];
    d_wdata    = dmem_wdata;
    case (state)
      CLEAR: begin
        d_we    = 1'b1;
        d_waddr = ptr[DA-1:0];
        d_wdata = '0;
      end
      LOAD: begin
        load_ready = 1'b1;
        i_we       = load_valid;
      end
      RUN: begin
        i_re = imem_en;
        d_re = dmem_ren;
        d_we = dmem_wen && !wr_oob;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else begin
      case (state)
        CLEAR:   ptr <= (ptr == D_LAST) ? '0 : ptr + 1'b1;
        LOAD:    if (beat) ptr <= ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // A full imem without load_last counts as an overflow. err_oob is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_oob    <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      core_rst_n <= (state_nx == RUN);
      if ((state == LOAD && beat && ptr == I_LAST && !load_last) ||
          (state == RUN && ((imem_en && i_oob) || (dmem_ren && rd_oob) ||
                            (dmem_wen && wr_oob))))
        err_oob <= 1'b1;
    end
  end

  sync_ram_1r1w #(.DEPTH(IMEM_DEPTH), .DATA_W(INST_DATA_W), .ADDR_W(IA)) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (i_we),
    .waddr (ptr[IA-1:0]),
    .wdata (load_data),
    .re    (i_re),
    .rzero (i_oob),
    .raddr (imem_addr[IA-1:0]),
    .rdata (imem_instr)
  );

  sync_ram_1r1w #(.DEPTH(DMEM_DEPTH), .DATA_W(DMEM_DATA_W), .ADDR_W(DA)) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .we    (d_we),
    .waddr (d_waddr),
    .wdata (d_wdata),
    .re    (d_re),
    .rzero (rd_oob),
    .raddr (dmem_raddr[DA-1:0]),
    .rdata (dmem_rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Small memories, directed phases plus random RUN traffic
// checked against array models of imem/dmem.
module tb_mem_responder;
  localparam int IAW = 12, IDW = 32, DAW = 12, DDW = 32, ID = 16, DD = 16;

  logic           clk = 1'b0, rst = 1'b0;
  logic           load_valid = 1'b0, load_ready, load_last = 1'b0, core_rst_n;
  logic [IDW-1:0] load_data = '0, imem_instr;
  logic           imem_en = 1'b0, dmem_wen = 1'b0, dmem_ren = 1'b0, err_oob;
  logic [IAW-1:0] imem_addr = '0;
  logic [DAW-1:0] dmem_waddr = '0, dmem_raddr = '0;
  logic [DDW-1:0] dmem_wdata = '0, dmem_rdata;

  mem_responder #(
    .INST_ADDR_W(IAW), .INST_DATA_W(IDW), .DMEM_ADDR_W(DAW), .DMEM_DATA_W(DDW),
    .IMEM_DEPTH(ID), .DMEM_DEPTH(DD)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .core_rst_n(core_rst_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .dmem_wen(dmem_wen), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m_imem [ID];
  logic [31:0] m_dmem [DD];
  logic [31:0] e_instr = '0, e_rdata = '0;
  logic        e_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    load_valid = 1'b0; load_last = 1'b0;
    imem_en = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
  endtask

  task automatic model_reset;
    e_instr = '0; e_rdata = '0; e_err = 1'b0;
  endtask

  // After rst has been released, count edges until load_ready (bounded).
  task automatic wait_clear(input string tag);
    int n = 0;
    chk({tag, ".ready_pre"}, {31'd0, load_ready}, 32'd0);
    while (!load_ready && n < 200) begin
      tick;
      n++;
    end
    chk({tag, ".clear_cycles"}, n, DD);
    for (int i = 0; i < DD; i++) m_dmem[i] = '0;
  endtask

  // One RUN cycle: drive a request set, update the model, and check all three outputs after the edge.
  task automatic run_cycle(input string tag, input bit ie, input int ia, input bit re,
                           input int ra, input bit we, input int wa, input logic [31:0] wd);
    imem_en = ie; imem_addr = IAW'(ia);
    dmem_ren = re; dmem_raddr = DAW'(ra);
    dmem_wen = we; dmem_waddr = DAW'(wa); dmem_wdata = wd;
    if (ie) begin
      e_instr = (ia < ID) ? m_imem[ia] : 32'd0;
      if (ia >= ID) e_err = 1'b1;
    end
    if (re) begin
      e_rdata = (ra < DD) ? m_dmem[ra] : 32'd0;
      if (ra >= DD) e_err = 1'b1;
    end
    if (we) begin
      if (wa < DD) m_dmem[wa] = wd;
      else         e_err = 1'b1;
    end
    tick;
    idle;
    chk({tag, ".instr"}, imem_instr, e_instr);
    chk({tag, ".rdata"}, dmem_rdata, e_rdata);
    chk({tag, ".err"}, {31'd0, err_oob}, {31'd0, e_err});
  endtask

  function automatic int rnd_addr(input int depth, input bit allow_oob);
    if (allow_oob && $urandom_range(0, 7) == 0) return int'($urandom_range(depth, 4095));
    return int'($urandom_range(0, depth - 1));
  endfunction

  initial begin
    logic [31:0] w [3];
    int acc;
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333;

    // Reset values
    idle;
    repeat (3) tick;
    chk("rst.load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst.core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("rst.instr", imem_instr, 32'd0);
    chk("rst.rdata", dmem_rdata, 32'd0);
    chk("rst.err", {31'd0, err_oob}, 32'd0);
    rst = 1'b1;
    wait_clear("clr1");

    // Three-beat program with random gaps
    for (int b = 0; b < 3; b++) begin
      repeat ($urandom_range(0, 3)) begin
        tick;
        chk("load.gap_core_rst", {31'd0, core_rst_n}, 32'd0);
      end
      load_valid = 1'b1; load_data = w[b]; load_last = (b == 2);
      tick;
      idle;
      m_imem[b] = w[b];
      chk("load.core_rst_n", {31'd0, core_rst_n}, (b == 2) ? 32'd1 : 32'd0);
    end
    chk("run.load_ready", {31'd0, load_ready}, 32'd0);

    // The cleared dmem reads back zero, and the program fetches back
    for (int a = 0; a < DD; a++) run_cycle("clr_rd", 0, 0, 1, a, 0, 0, '0);
    for (int a = 0; a < 3; a++) run_cycle("fetch", 1, a, 0, 0, 0, 0, '0);

    // Write then read, followed by a same-cycle read/write (read-first)
    run_cycle("wr5", 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    run_cycle("rd5", 0, 0, 1, 5, 0, 0, '0);
    chk("rd5.const", dmem_rdata, 32'hDEADBEEF);
    run_cycle("rw5", 0, 0, 1, 5, 1, 5, 32'hCAFEF00D);
    chk("rw5.old", dmem_rdata, 32'hDEADBEEF);
    run_cycle("rd5b", 0, 0, 1, 5, 0, 0, '0);
    chk("rd5b.new", dmem_rdata, 32'hCAFEF00D);

    // Random in-range traffic; err must stay clear
    for (int i = 0; i < 200; i++)
      run_cycle("rnd_in", $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 1),
                rnd_addr(DD, 0), $urandom_range(0, 1), rnd_addr(DD, 0), $urandom);

    // Out-of-range read and write
    run_cycle("oob_rd", 0, 0, 1, 2000, 0, 0, '0);
    chk("oob_rd.zero", dmem_rdata, 32'd0);
    chk("oob_rd.err", {31'd0, err_oob}, 32'd1);
    run_cycle("oob_wr", 0, 0, 0, 0, 1, 2000, 32'h12345678);
    for (int a = 0; a < DD; a++) run_cycle("post_oob", 0, 0, 1, a, 0, 0, '0);

    // Reset mid-LOAD after two beats
    rst = 1'b0;
    model_reset;
    repeat (2) tick;
    rst = 1'b1;
    wait_clear("clr2");
    for (int b = 0; b < 2; b++) begin
      load_valid = 1'b1; load_data = $urandom;
      tick;
    end
    #3 rst = 1'b0;
    #1;
    chk("midrst.core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("midrst.load_ready", {31'd0, load_ready}, 32'd0);
    chk("midrst.err", {31'd0, err_oob}, 32'd0);
    chk("midrst.rdata", dmem_rdata, 32'd0);
    idle;
    model_reset;
    repeat (2) tick;
    rst = 1'b1;
    wait_clear("clr3");

    // Overflowing load: IMEM_DEPTH+2 beats with load_last never set
    acc = 0;
    for (int i = 0; i < ID + 2; i++) begin
      load_valid = 1'b1; load_last = 1'b0; load_data = $urandom;
      if (load_ready) begin
        if (acc < ID) m_imem[acc] = load_data;
        acc++;
      end
      tick;
    end
    idle;
    e_err = 1'b1;
    chk("ovf.accepted", acc, ID);
    chk("ovf.err", {31'd0, err_oob}, 32'd1);
    chk("ovf.core_rst_n", {31'd0, core_rst_n}, 32'd1);
    chk("ovf.load_ready", {31'd0, load_ready}, 32'd0);

    // The new program starts at word 0, and dmem was cleared again
    for (int a = 0; a < ID; a++) run_cycle("ovf_fetch", 1, a, 0, 0, 0, 0, '0);
    run_cycle("reclr_rd5", 0, 0, 1, 5, 0, 0, '0);
    chk("reclr_rd5.zero", dmem_rdata, 32'd0);

    // Random mixed traffic, including out-of-range addresses
    for (int i = 0; i < 300; i++)
      run_cycle("rnd_mix", $urandom_range(0, 1), rnd_addr(ID, 1), $urandom_range(0, 1),
                rnd_addr(DD, 1), $urandom_range(0, 1), rnd_addr(DD, 1), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
